curl_pow_sequencer: RTL and testbench
=====================================

CURL_POW_SEQUENCER -- requirements
Module: curl_pow_sequencer

Interface
REQ-001 Parameter: HASH_CNT_WIDTH, default 32, width of the PoW hash-attempt counter.
REQ-002 Clocking SHALL be as follows: one clock; reset is asynchronous and active-high.
REQ-003 i_clk  in  1  sole clock, rising edge.
REQ-004 i_arst  in  1  asynchronous active-high reset.
REQ-005 i_s_valid / o_s_ready  in/out  1 each  job word stream handshake.
REQ-006 i_s_data  in  54  27 trits, 2 bits per trit, trit k at bits [2k+1:2k].
REQ-007 i_s_last  in  1  marks the final word of a job.
REQ-008 i_s_pow  in  1  job type, sampled on the first word of a job: 1 = PoW on the final block, 0 = transform only.
REQ-009 i_s_mwm_mask  in  32  MWM mask, sampled on the first word of a job.
REQ-010 o_core_we, o_core_addr[3:0], o_core_data[53:0]  out  registered state-word write port to the Curl core.
REQ-011 o_core_transform, o_core_pow  out  1 each  single-cycle start pulses to the core.
REQ-012 o_core_mwm_mask  out  32  mask held stable from the job's first word until the result handshake.
REQ-013 i_core_transforming, i_core_pow_hash_finish, i_core_pow_finish  in  1 each  core status.
REQ-014 i_core_nonce  in  162  registered nonce output of the core.
REQ-015 o_r_valid / i_r_ready  out/in  1 each  result handshake.
REQ-016 o_r_nonce  out  162  winning nonce.
REQ-017 o_r_hashes  out  HASH_CNT_WIDTH  number of PoW hash attempts.
REQ-018 o_r_err  out  1  job rejected.
REQ-019 o_busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have these states: IDLE, LOAD, PAD, ISSUE, WAIT_T, WAIT_P, CHECK, RESULT.
REQ-021 A block SHALL be 9 words written to core addresses 0..8 in order; a word index counter (0..8) SHALL wrap to 0 after index 8.
REQ-022 o_s_ready SHALL be high only in IDLE and LOAD.
REQ-023 Each accepted word SHALL appear on o_core_we/addr/data exactly one cycle later, as a 1-cycle pulse.
REQ-024 If i_s_last is accepted at index < 8, PAD SHALL write all-zero words to the remaining addresses, one per cycle, through index 8.
REQ-025 After the index-8 write is registered, ISSUE SHALL select the action:
- non-final block: o_core_transform pulse;
- final block of a transform job: o_core_transform pulse;
- final block of a PoW job: o_core_pow pulse.
REQ-026 WAIT_T SHALL ignore i_core_transforming on its first cycle and thereafter wait for i_core_transforming = 0.
REQ-027 On leaving WAIT_T, the FSM SHALL go to LOAD for a non-final block and to RESULT for the final block, with o_r_nonce = 0 and o_r_hashes = 0.
REQ-028 A PoW job whose final block is also its first block SHALL issue no core command and SHALL go to RESULT with o_r_err = 1, because the core's pow-finish flag is cleared only by a transform.
REQ-029 In WAIT_P, each i_core_pow_hash_finish pulse SHALL increment the hash counter (saturating at all-ones) and enter CHECK.
REQ-030 CHECK SHALL last exactly one cycle:
- i_core_pow_finish = 1: capture i_core_nonce into o_r_nonce, then go to RESULT;
- otherwise: return to WAIT_P.
REQ-031 o_r_valid SHALL stay high in RESULT until i_r_ready; on the handshake cycle the FSM SHALL go to IDLE and clear all job counters.
REQ-032 The o_core_transform and o_core_pow pulses SHALL never be asserted in the same cycle, nor in a cycle in which o_core_we is asserted.
REQ-033 A stream word arriving while o_s_ready = 0 SHALL be held off and never dropped.

Reset
REQ-034 While i_arst is asserted, the FSM SHALL be in IDLE and all outputs SHALL be 0, including o_core_mwm_mask, o_r_nonce and o_r_hashes.
REQ-035 Reset asserted mid-job SHALL abandon the job without issuing further core commands; the core is reset in the same domain.

Structure
REQ-036 A shared package SHALL hold: WORD_BITS = 54, WORDS_PER_BLOCK = 9, NONCE_BITS = 162, MWM_BITS = 32, and the FSM state enum.
REQ-037 The design SHALL be a single module with no sub-module; the hash counter is inline.

Verification
REQ-038 Directed scenario: 2-block transform job (18 words, last on index 8) -> two transform pulses; result with nonce 0, hashes 0, err 0.
REQ-039 Directed scenario: 1-block PoW job -> no core_pow pulse; o_r_err = 1.
REQ-040 Directed scenario: 11-block PoW job with a core model that succeeds on the 3rd hash_finish pulse -> 10 transforms, 1 pow pulse; o_r_hashes = 3; o_r_nonce = the model's nonce.
REQ-041 Directed scenario: job with last word at index 4 -> addresses 5..8 written with 0, then a transform pulse.
REQ-042 Directed scenario: i_r_ready held low for 10 cycles -> o_r_valid held and results stable; o_s_ready = 0 throughout.
REQ-043 Directed scenario: i_arst pulsed during WAIT_P -> all outputs 0 in the next cycle; a new job is accepted afterwards.

Source files
------------

// File: rtl/curl_pow_sequencer_pkg.sv
// Shared constants and FSM state encoding for the Curl PoW job sequencer.
//   WORD_BITS       : width of one state word (27 trits x 2 bits)
//   WORDS_PER_BLOCK : state words per Curl block (core addresses 0..8)
//   NONCE_BITS      : width of the winning nonce reported by the core
//   MWM_BITS        : width of the min-weight-magnitude mask
package curl_pow_sequencer_pkg;

  localparam int WORD_BITS       = 54;
  localparam int WORDS_PER_BLOCK = 9;
  localparam int NONCE_BITS      = 162;
  localparam int MWM_BITS        = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    ISSUE,
    WAIT_T,
    WAIT_P,
    CHECK,
    RESULT
  } state_t;

endpackage

// File: rtl/curl_pow_sequencer.sv
// Curl PoW job sequencer.
// Takes a stream of 54-bit state words, writes them into the Curl core one
// block (9 words) at a time, fires a transform per non-final block and either
// a transform or a PoW start on the final block, then reports the result.
// Ports:
//   i_clk, i_arst                         clock, async active-high reset
//   i_s_valid/o_s_ready, i_s_data,
//   i_s_last, i_s_pow, i_s_mwm_mask       job word stream (pow/mask taken from first word)
//   o_core_we/addr/data                   registered state-word write port
//   o_core_transform, o_core_pow          single-cycle core start pulses
//   o_core_mwm_mask                       mask held for the whole job
//   i_core_transforming,
//   i_core_pow_hash_finish,
//   i_core_pow_finish, i_core_nonce       core status
//   o_r_valid/i_r_ready, o_r_nonce,
//   o_r_hashes, o_r_err                   result handshake
//   o_busy                                high whenever not IDLE
module curl_pow_sequencer
  import curl_pow_sequencer_pkg::*;
#(
  parameter int HASH_CNT_WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_s_valid,
  output logic                      o_s_ready,
  input  logic [WORD_BITS-1:0]      i_s_data,
  input  logic                      i_s_last,
  input  logic                      i_s_pow,
  input  logic [MWM_BITS-1:0]       i_s_mwm_mask,
  output logic                      o_core_we,
  output logic [3:0]                o_core_addr,
  output logic [WORD_BITS-1:0]      o_core_data,
  output logic                      o_core_transform,
  output logic                      o_core_pow,
  output logic [MWM_BITS-1:0]       o_core_mwm_mask,
  input  logic                      i_core_transforming,
  input  logic                      i_core_pow_hash_finish,
  input  logic                      i_core_pow_finish,
  input  logic [NONCE_BITS-1:0]     i_core_nonce,
  output logic                      o_r_valid,
  input  logic                      i_r_ready,
  output logic [NONCE_BITS-1:0]     o_r_nonce,
  output logic [HASH_CNT_WIDTH-1:0] o_r_hashes,
  output logic                      o_r_err,
  output logic                      o_busy
);

  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLOCK - 1);

  state_t     state;
  logic [3:0] idx;        // word index within the current block
  logic       job_pow;    // job type latched from the first word
  logic       first_blk;  // current block is the job's first block
  logic       final_blk;  // last word of the job has been accepted
  logic       wt_first;   // first cycle of WAIT_T: core has not yet raised transforming
  logic       acc;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign o_s_ready = ~i_arst & ((state == IDLE) | (state == LOAD));
  assign acc       = i_s_valid & o_s_ready;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state            <= IDLE;
      idx              <= '0;
      job_pow          <= 1'b0;
      first_blk        <= 1'b0;
      final_blk        <= 1'b0;
      wt_first         <= 1'b0;
      o_core_we        <= 1'b0;
      o_core_addr      <= '0;
      o_core_data      <= '0;
      o_core_transform <= 1'b0;
      o_core_pow       <= 1'b0;
      o_core_mwm_mask  <= '0;
      o_r_valid        <= 1'b0;
      o_r_nonce        <= '0;
      o_r_hashes       <= '0;
      o_r_err          <= 1'b0;
    end else begin
      o_core_we        <= 1'b0;
      o_core_transform <= 1'b0;
      o_core_pow       <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (acc) begin
            o_core_we   <= 1'b1;
            o_core_addr <= idx;
            o_core_data <= i_s_data;
            if (state == IDLE) begin
              job_pow         <= i_s_pow;
              o_core_mwm_mask <= i_s_mwm_mask;
              first_blk       <= 1'b1;
            end
            if (i_s_last) final_blk <= 1'b1;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ISSUE;
            end else begin
              idx   <= idx + 4'd1;
              state <= i_s_last ? PAD : LOAD;
            end
          end
        end
        PAD: begin
          o_core_we   <= 1'b1;
          o_core_addr <= idx;
          o_core_data <= '0;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= ISSUE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        // The index-8 write is on the port this cycle; the command pulse
        // lands next cycle so it never overlaps a write.
        ISSUE: begin
          if (final_blk && job_pow) begin
            if (first_blk) begin
              // The core's pow-finish flag is only cleared by a transform, so a
              // single-block PoW could report a stale win: reject it.
              o_r_err   <= 1'b1;
              o_r_valid <= 1'b1;
              state     <= RESULT;
            end else begin
              o_core_pow <= 1'b1;
              state      <= WAIT_P;
            end
          end else begin
            o_core_transform <= 1'b1;
            wt_first         <= 1'b1;
            state            <= WAIT_T;
          end
        end
        WAIT_T: begin
          wt_first <= 1'b0;
          if (!wt_first && !i_core_transforming) begin
            if (final_blk) begin
              o_r_nonce  <= '0;
              o_r_hashes <= '0;
              o_r_valid  <= 1'b1;
              state      <= RESULT;
            end else begin
              first_blk <= 1'b0;
              state     <= LOAD;
            end
          end
        end
        WAIT_P: begin
          if (i_core_pow_hash_finish) begin
            if (o_r_hashes != '1) o_r_hashes <= o_r_hashes + HASH_CNT_WIDTH'(1);
            state <= CHECK;
          end
        end
        CHECK: begin
          if (i_core_pow_finish) begin
            o_r_nonce <= i_core_nonce;
            o_r_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            state <= WAIT_P;
          end
        end
        RESULT: begin
          if (i_r_ready) begin
            o_r_valid       <= 1'b0;
            o_r_nonce       <= '0;
            o_r_hashes      <= '0;
            o_r_err         <= 1'b0;
            o_core_mwm_mask <= '0;
            idx             <= '0;
            job_pow         <= 1'b0;
            first_blk       <= 1'b0;
            final_blk       <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_curl_pow_sequencer.sv
// Scoreboard bench for curl_pow_sequencer: stimulus pushes expected core
// writes and job results into queues; a negedge monitor pops and compares.
module tb_curl_pow_sequencer;

  localparam logic [161:0] MODEL_NONCE = {2'b10, 32'hDEADBEEF, 128'h0123456789ABCDEF_FEDCBA9876543210};
  localparam int           WIN_PULSE   = 3;

  typedef struct {
    logic [161:0] nonce;
    logic [31:0]  hashes;
    logic         err;
    logic [31:0]  mask;
    int           ntr;
    int           npw;
  } res_t;

  logic         i_clk = 1'b0;
  logic         i_arst = 1'b1;
  logic         i_s_valid = 1'b0;
  logic         o_s_ready;
  logic [53:0]  i_s_data = '0;
  logic         i_s_last = 1'b0;
  logic         i_s_pow = 1'b0;
  logic [31:0]  i_s_mwm_mask = '0;
  logic         o_core_we;
  logic [3:0]   o_core_addr;
  logic [53:0]  o_core_data;
  logic         o_core_transform;
  logic         o_core_pow;
  logic [31:0]  o_core_mwm_mask;
  logic         i_core_transforming;
  logic         i_core_pow_hash_finish;
  logic         i_core_pow_finish;
  logic [161:0] i_core_nonce;
  logic         o_r_valid;
  logic         i_r_ready = 1'b1;
  logic [161:0] o_r_nonce;
  logic [31:0]  o_r_hashes;
  logic         o_r_err;
  logic         o_busy;

  int checks = 0;
  int errors = 0;
  res_t        rq[$];
  logic [57:0] wq[$];
  int n_tr = 0;
  int n_pw = 0;

  curl_pow_sequencer #(.HASH_CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_data(i_s_data),
    .i_s_last(i_s_last), .i_s_pow(i_s_pow), .i_s_mwm_mask(i_s_mwm_mask),
    .o_core_we(o_core_we), .o_core_addr(o_core_addr), .o_core_data(o_core_data),
    .o_core_transform(o_core_transform), .o_core_pow(o_core_pow),
    .o_core_mwm_mask(o_core_mwm_mask),
    .i_core_transforming(i_core_transforming),
    .i_core_pow_hash_finish(i_core_pow_hash_finish),
    .i_core_pow_finish(i_core_pow_finish), .i_core_nonce(i_core_nonce),
    .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_nonce(o_r_nonce),
    .o_r_hashes(o_r_hashes), .o_r_err(o_r_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Core model: transform keeps transforming high 3 cycles and clears the
  // pow-finish flag; PoW emits a hash_finish every 4 cycles and wins on
  // pulse WIN_PULSE (pow_finish and nonce registered with that pulse).
  int   t_cnt, h_timer, h_pulses;
  logic pow_run;
  always @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      i_core_transforming <= 1'b0; i_core_pow_hash_finish <= 1'b0;
      i_core_pow_finish <= 1'b0; i_core_nonce <= '0;
      t_cnt <= 0; h_timer <= 0; h_pulses <= 0; pow_run <= 1'b0;
    end else begin
      i_core_pow_hash_finish <= 1'b0;
      if (o_core_transform) begin
        i_core_transforming <= 1'b1; t_cnt <= 3; i_core_pow_finish <= 1'b0;
      end else if (t_cnt != 0) begin
        t_cnt <= t_cnt - 1;
        if (t_cnt == 1) i_core_transforming <= 1'b0;
      end
      if (o_core_pow) begin
        pow_run <= 1'b1; h_timer <= 4; h_pulses <= 0;
      end else if (pow_run) begin
        if (h_timer == 1) begin
          i_core_pow_hash_finish <= 1'b1;
          h_pulses <= h_pulses + 1;
          if (h_pulses + 1 == WIN_PULSE) begin
            i_core_pow_finish <= 1'b1; i_core_nonce <= MODEL_NONCE; pow_run <= 1'b0;
          end else h_timer <= 4;
        end else h_timer <= h_timer - 1;
      end
    end
  end

  // Monitor
  always @(negedge i_clk) begin
    if (i_arst) begin
      n_tr = 0; n_pw = 0;
    end else begin
      chk("pulse_exclusive", 192'((o_core_transform & o_core_pow) |
          ((o_core_transform | o_core_pow) & o_core_we)), 192'(0));
      if (o_core_transform) n_tr++;
      if (o_core_pow) n_pw++;
      if (o_core_we) begin
        if (wq.size() == 0) chk("unexpected_write", 192'({o_core_addr, o_core_data}), 192'(0));
        else begin
          logic [57:0] w;
          w = wq.pop_front();
          chk("write_addr", 192'(o_core_addr), 192'(w[57:54]));
          chk("write_data", 192'(o_core_data), 192'(w[53:0]));
        end
      end
      if (o_r_valid && i_r_ready) begin
        if (rq.size() == 0) chk("unexpected_result", 192'(o_r_valid), 192'(0));
        else begin
          res_t r;
          r = rq.pop_front();
          chk("r_nonce", 192'(o_r_nonce), 192'(r.nonce));
          chk("r_hashes", 192'(o_r_hashes), 192'(r.hashes));
          chk("r_err", 192'(o_r_err), 192'(r.err));
          chk("mwm_mask", 192'(o_core_mwm_mask), 192'(r.mask));
          chk("n_transform", 192'(n_tr), 192'(r.ntr));
          chk("n_pow", 192'(n_pw), 192'(r.npw));
        end
        n_tr = 0; n_pw = 0;
      end
    end
  end

  task automatic send_job(input int nw, input logic pw, input logic [31:0] mask, input int tag);
    int   nb;
    res_t r;
    nb = (nw + 8) / 9;
    r.mask = mask; r.nonce = '0; r.hashes = '0; r.err = 1'b0; r.ntr = nb; r.npw = 0;
    if (pw && nb == 1) begin r.err = 1'b1; r.ntr = 0; end
    else if (pw) begin r.ntr = nb - 1; r.npw = 1; r.hashes = WIN_PULSE; r.nonce = MODEL_NONCE; end
    rq.push_back(r);
    for (int k = 0; k < nw; k++) begin
      int t;
      t = 0;
      i_s_valid    = 1'b1;
      i_s_data     = {6'(tag), 16'hA5C3, 32'(k * 7 + 1)};
      i_s_last     = (k == nw - 1);
      // pow/mask only matter on the first word; drive junk elsewhere
      i_s_pow      = (k == 0) ? pw : ~pw;
      i_s_mwm_mask = (k == 0) ? mask : ~mask;
      wq.push_back({4'(k % 9), i_s_data});
      while (!o_s_ready && t < 500) begin @(negedge i_clk); t++; end
      if (t >= 500) chk("stream_timeout", 192'(t), 192'(0));
      @(negedge i_clk);
    end
    i_s_valid = 1'b0; i_s_last = 1'b0;
    if (nw % 9 != 0)
      for (int a = nw % 9; a < 9; a++) wq.push_back({4'(a), 54'd0});
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((o_busy || rq.size() != 0) && t < 3000) begin @(negedge i_clk); t++; end
    if (t >= 3000) chk("idle_timeout", 192'(t), 192'(0));
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_ctl"}, 192'({o_s_ready, o_core_we, o_core_transform, o_core_pow,
                            o_r_valid, o_r_err, o_busy}), 192'(0));
    chk({nm, "_core"}, 192'({o_core_addr, o_core_data, o_core_mwm_mask}), 192'(0));
    chk({nm, "_nonce"}, 192'(o_r_nonce), 192'(0));
    chk({nm, "_hashes"}, 192'(o_r_hashes), 192'(0));
  endtask

  initial begin
    @(negedge i_clk);
    chk_zero_outputs("reset");
    @(negedge i_clk);
    i_arst = 1'b0;
    @(negedge i_clk);

    send_job(18, 1'b0, 32'h1234_5678, 1);   // 2-block transform, last on index 8
    send_job(9,  1'b1, 32'hFFFF_0000, 2);   // 1-block PoW -> rejected
    send_job(99, 1'b1, 32'h0000_03FF, 3);   // 11-block PoW, wins on 3rd hash
    send_job(5,  1'b0, 32'hA5A5_A5A5, 4);   // last at index 4 -> zero pad 5..8
    wait_idle();

    // Result held while consumer stalls
    i_r_ready = 1'b0;
    send_job(3, 1'b0, 32'h0BAD_F00D, 5);
    begin
      int t;
      t = 0;
      while (!o_r_valid && t < 500) begin @(negedge i_clk); t++; end
      if (t >= 500) chk("valid_timeout", 192'(t), 192'(0));
    end
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 192'(o_r_valid), 192'(1));
      chk("stall_s_ready", 192'(o_s_ready), 192'(0));
      chk("stall_nonce", 192'(o_r_nonce), 192'(rq[0].nonce));
      chk("stall_hashes", 192'(o_r_hashes), 192'(rq[0].hashes));
      chk("stall_err", 192'(o_r_err), 192'(rq[0].err));
      @(negedge i_clk);
    end
    i_r_ready = 1'b1;
    wait_idle();

    // Reset during WAIT_P
    send_job(18, 1'b1, 32'hCAFE_0001, 6);
    begin
      int t;
      t = 0;
      while (!o_core_pow && t < 500) begin @(negedge i_clk); t++; end
      if (t >= 500) chk("pow_timeout", 192'(t), 192'(0));
    end
    @(negedge i_clk);
    @(negedge i_clk);
    chk("busy_in_wait_p", 192'(o_busy), 192'(1));
    i_arst = 1'b1;
    @(negedge i_clk);
    chk_zero_outputs("midjob_reset");
    i_arst = 1'b0;
    rq.delete();
    wq.delete();
    @(negedge i_clk);

    send_job(9, 1'b0, 32'h0000_0001, 7);    // new job after reset
    wait_idle();
    chk("wq_drained", 192'(wq.size()), 192'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
